// File: rtl/ip_debugger_pkg.sv
// Shared constants, state encoding and hex helper for the multi-channel UART debug dumper.
package ip_debugger_pkg;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    // Uppercase hex digit: 0..9 -> '0'..'9', A..F -> 'A'..'F'.
    function automatic logic [7:0] func_hex2ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return 8'h30 + {4'h0, nibble};
        else
            return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/ip_debugger_trigger.sv
// Key edge detection, auto-mode toggle, period counter and the merged pending-dump flag.
module ip_debugger_trigger #(
    parameter int PERIOD = 27_000_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [1:0] keys,
    input  logic       take,
    output logic       pending,
    output logic       auto_mode
);

    localparam int                CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [1:0]       ff_keys;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt;
    logic             auto_q;
    logic             pending_q;
    logic             wrap;
    logic             trig;

    assign press     = keys & ~ff_keys;
    assign wrap      = auto_q && (cnt == CNT_LAST);
    assign trig      = press[0] | wrap;
    // A trigger in the same cycle the FSM is idle is consumed directly,
    // so a key press reaches LOAD on the very next cycle.
    assign pending   = pending_q | trig;
    assign auto_mode = auto_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ff_keys   <= 2'b00;
            auto_q    <= 1'b0;
            cnt       <= '0;
            pending_q <= 1'b0;
        end else begin
            ff_keys <= keys;
            if (press[1])
                auto_q <= ~auto_q;
            // A toggle clears the counter even when it coincides with a wrap;
            // the wrap's trigger has already been folded into pending.
            if (press[1] || !auto_q || wrap)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            pending_q <= take ? 1'b0 : pending;
        end
    end

endmodule

// File: rtl/ip_debugger_mch.sv
// Multi-channel debug dumper: snapshots N_CH probe words and streams "CHk:XXXX ... CR LF" to the UART.
module ip_debugger_mch
    import ip_debugger_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CH_WIDTH = 16,
    parameter int PERIOD   = 27_000_000
) (
    input  logic                     clk,
    input  logic                     n_reset,
    output logic [7:0]               send_data,
    output logic                     send_req,
    input  logic                     send_busy,
    input  logic [1:0]               keys,
    input  logic [N_CH*CH_WIDTH-1:0] probe,
    output logic                     dumping,
    output logic                     auto_mode
);

    localparam int               NIB     = CH_WIDTH / 4;
    localparam int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Field index within one channel: 0..3 prefix, 4.. digits, then separator, then LF.
    localparam logic [3:0]       FLD_SEP = 4'(4 + NIB);
    localparam logic [3:0]       FLD_LF  = 4'(5 + NIB);
    localparam logic [3:0]       DIG_TOP = 4'(3 + NIB);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    state_t              state;
    state_t              state_next;
    logic [CH_WIDTH-1:0] snap [N_CH];
    logic [CH_W-1:0]     ch_idx;
    logic [3:0]          fld;
    logic                pending;
    logic                take;
    logic                accept;
    logic                last_byte;
    logic [CH_WIDTH-1:0] cur_word;
    logic [3:0]          dig;
    logic [3:0]          nib;
    logic [7:0]          cur_byte;

    assign take      = (state == ST_IDLE) && pending;
    assign accept    = (state == ST_SEND) && !send_busy;
    assign last_byte = (fld == FLD_LF);

    ip_debugger_trigger #(
        .PERIOD (PERIOD)
    ) u_trigger (
        .clk       (clk),
        .n_reset   (n_reset),
        .keys      (keys),
        .take      (take),
        .pending   (pending),
        .auto_mode (auto_mode)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pending) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: if (accept) state_next = last_byte ? ST_IDLE : ST_GAP;
            ST_GAP:  state_next = ST_SEND;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: snap is a plain data store written in LOAD and only read afterwards,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            for (int k = 0; k < N_CH; k++)
                snap[k] <= probe[k*CH_WIDTH +: CH_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ch_idx <= '0;
            fld    <= '0;
        end else if (state == ST_LOAD) begin
            ch_idx <= '0;
            fld    <= '0;
        end else if (accept && !last_byte) begin
            if (fld == FLD_SEP) begin
                if (ch_idx == LAST_CH) begin
                    fld <= FLD_LF;
                end else begin
                    ch_idx <= ch_idx + 1'b1;
                    fld    <= '0;
                end
            end else begin
                fld <= fld + 1'b1;
            end
        end
    end

    // Digit fields run most significant nibble first.
    always_comb begin
        cur_word = snap[ch_idx];
        dig      = DIG_TOP - fld;
        nib      = '0;
        for (int i = 0; i < NIB; i++)
            if (dig == 4'(i))
                nib = cur_word[i*4 +: 4];
    end

    always_comb begin
        cur_byte = 8'h00;
        case (fld)
            4'd0:    cur_byte = ASCII_C;
            4'd1:    cur_byte = ASCII_H;
            4'd2:    cur_byte = func_hex2ascii(4'(ch_idx));
            4'd3:    cur_byte = ASCII_COLON;
            default: begin
                if (fld == FLD_LF)
                    cur_byte = ASCII_LF;
                else if (fld == FLD_SEP)
                    cur_byte = (ch_idx == LAST_CH) ? ASCII_CR : ASCII_SPACE;
                else
                    cur_byte = func_hex2ascii(nib);
            end
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    assign send_req  = (state == ST_SEND);
    assign send_data = (state == ST_SEND) ? cur_byte : 8'h00;
    assign dumping   = (state == ST_SEND) || (state == ST_GAP);

endmodule

// File: tb/tb_ip_debugger_mch.sv
// Scoreboard bench for ip_debugger_mch (2 channels x 16 bits, auto period 100).
module tb_ip_debugger_mch;

    localparam int N_CH       = 2;
    localparam int CH_WIDTH   = 16;
    localparam int NIB        = CH_WIDTH / 4;
    localparam int PERIOD     = 100;
    localparam int LINE_BYTES = N_CH * (4 + NIB) + (N_CH - 1) + 2;

    logic                     clk = 1'b0;
    logic                     n_reset = 1'b0;
    logic [7:0]               send_data;
    logic                     send_req;
    logic                     send_busy = 1'b0;
    logic [1:0]               keys = 2'b00;
    logic [N_CH*CH_WIDTH-1:0] probe = '0;
    logic                     dumping;
    logic                     auto_mode;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q [$];
    int         rise_q [$];
    int         lf_count = 0;
    int         acc_count = 0;
    int         lf_cyc = 0;
    int         first_req_cyc = -1;
    bit         arm_first = 1'b0;
    bit         busy_mode = 1'b0;

    ip_debugger_mch #(
        .N_CH     (N_CH),
        .CH_WIDTH (CH_WIDTH),
        .PERIOD   (PERIOD)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .send_data (send_data),
        .send_req  (send_req),
        .send_busy (send_busy),
        .keys      (keys),
        .probe     (probe),
        .dumping   (dumping),
        .auto_mode (auto_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    function automatic void push_line(input logic [N_CH*CH_WIDTH-1:0] p);
        for (int k = 0; k < N_CH; k++) begin
            exp_q.push_back(8'h43);
            exp_q.push_back(8'h48);
            exp_q.push_back(hex_char(4'(k)));
            exp_q.push_back(8'h3A);
            for (int d = NIB - 1; d >= 0; d--)
                exp_q.push_back(hex_char(p[k*CH_WIDTH + d*4 +: 4]));
            if (k < N_CH - 1)
                exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // One-cycle key pulse; t is the cycle in which the key is seen high.
    task automatic press(input int idx, output int t);
        @(posedge clk); #1;
        keys[idx] = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        keys[idx] = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dumping) break;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_idle"}, dumping, 1'b0);
    endtask

    // UART side: consumes accepted bytes against the scoreboard and models send_busy.
    initial begin
        bit         prev_req = 1'b0;
        bit         prev_acc = 1'b0;
        bit         prev_dump = 1'b0;
        bit         acc;
        int         busy_cnt = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            acc = send_req && !send_busy;
            if (prev_req && !prev_acc && n_reset)
                check("req_held", send_req, 1'b1);
            if (send_req && prev_req)
                check("data_stable", send_data, held);
            if (send_req && !prev_req) begin
                held = send_data;
                if (arm_first) begin
                    first_req_cyc = cyc;
                    arm_first = 1'b0;
                end
            end
            if (acc) begin
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", acc_count), send_data, e);
                    acc_count++;
                    if (e == 8'h0A) begin
                        lf_count++;
                        lf_cyc = cyc;
                    end
                end
            end
            if (dumping && !prev_dump)
                rise_q.push_back(cyc);
            prev_req  = send_req;
            prev_acc  = acc;
            prev_dump = dumping;
            @(posedge clk); #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) send_busy = 1'b0;
            end
            if (acc && busy_mode) begin
                send_busy = 1'b1;
                busy_cnt  = 5;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int t, t2, lf0, rise0, acc0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_send_req", send_req, 1'b0);
        check("rst_send_data", send_data, 8'h00);
        check("rst_dumping", dumping, 1'b0);
        check("rst_auto_mode", auto_mode, 1'b0);
        @(negedge clk) n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single dump, UART always ready
        probe = 32'hBEEF_1234;
        lf0 = lf_count;
        push_line(probe);
        arm_first = 1'b1;
        press(0, t);
        wait_done("line1");
        check("first_req_latency", first_req_cyc, t + 2);
        check("dump_rise", rise_q[$], t + 2);
        check("line_span", lf_cyc - first_req_cyc + 1, 2 * LINE_BYTES - 1);
        check("line1_count", lf_count - lf0, 1);

        // UART busy for 5 cycles after every accepted byte
        busy_mode = 1'b1;
        lf0 = lf_count;
        push_line(probe);
        press(0, t);
        wait_done("busy");
        busy_mode = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_count", lf_count - lf0, 1);

        // Probe changes one cycle after LOAD must not reach the line
        lf0 = lf_count;
        push_line(probe);
        press(0, t);
        @(posedge clk); #1;
        probe = '0;
        wait_done("snap");
        check("snap_count", lf_count - lf0, 1);

        // Three presses during a dump merge into exactly one extra line
        probe = 32'hBEEF_1234;
        lf0 = lf_count;
        rise0 = rise_q.size();
        push_line(probe);
        press(0, t);
        repeat (8) @(posedge clk);
        #1 probe = 32'hCAFE_0042;
        push_line(probe);
        press(0, t2);
        press(0, t2);
        press(0, t2);
        wait_done("merge");
        repeat (50) @(negedge clk);
        check("merge_idle", dumping, 1'b0);
        check("merge_lines", lf_count - lf0, 2);
        check("merge_dumps", rise_q.size() - rise0, 2);

        // Auto mode: auto_mode rises at t+1, LOADs follow PERIOD and 2*PERIOD later
        probe = 32'hBEEF_1234;
        rise0 = rise_q.size();
        push_line(probe);
        push_line(probe);
        press(1, t);
        check("auto_on", auto_mode, 1'b1);
        wait_done("auto");
        press(1, t2);
        check("auto_off", auto_mode, 1'b0);
        repeat (250) @(negedge clk);
        check("auto_dumps", rise_q.size() - rise0, 2);
        if (rise_q.size() - rise0 >= 2) begin
            check("auto_first", rise_q[rise0], t + 1 + PERIOD + 1);
            check("auto_second", rise_q[rise0 + 1], t + 1 + 2 * PERIOD + 1);
        end
        check("auto_off_quiet", exp_q.size(), 0);

        // Reset after the 7th accepted byte abandons the line
        acc0 = acc_count;
        push_line(probe);
        press(0, t);
        for (int i = 0; i < 200 && acc_count < acc0 + 7; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (send_req) break;
        end
        check("req_pre_rst", send_req, 1'b1);
        n_reset = 1'b0;
        #1;
        check("rst_req_async", send_req, 1'b0);
        check("rst_data_async", send_data, 8'h00);
        check("rst_dumping_async", dumping, 1'b0);
        check("rst_accepted", acc_count - acc0, 7);
        exp_q.delete();
        lf0 = lf_count;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_lf", lf_count - lf0, 0);
        push_line(probe);
        press(0, t);
        wait_done("post_rst");
        check("post_rst_line", lf_count - lf0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
